// File: rtl/score_display_ctrl_pkg.sv
// Shared state encodings and BCD limits for the score display controller.
package score_display_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PLAY       = 2'd1,
        OVER_SCORE = 2'd2,
        OVER_HIGH  = 2'd3
    } state_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

endpackage

// File: rtl/score_display_ctrl_bcd2_sat_inc.sv
// Two-digit BCD incrementer that saturates at 99.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module bcd2_sat_inc
    import score_display_ctrl_pkg::*;
(
    input  logic [7:0] val,
    output logic [7:0] inc
);

    logic [3:0] tens;
    logic [3:0] ones;

    assign tens = val[7:4];
    assign ones = val[3:0];

    always_comb begin
        inc = val;
        if (val >= BCD_MAX) begin
            inc = BCD_MAX;
        end else if (ones >= 4'd9) begin
            inc = {tens + 4'd1, 4'd0};
        end else begin
            inc = {tens, ones + 4'd1};
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Owns the game score and high score and sequences what the scanner shows.
// Latency: display outputs follow an input pulse one clk after it is sampled.
// Backpressure: none; start/point/crash are single-cycle pulses, always accepted.
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int ALT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       point,
    input  logic       crash,
    output logic [7:0] disp_value,
    output logic       disp_blank,
    output logic       new_record,
    output logic [1:0] game_state
);

    localparam int TW = (ALT_CYCLES > 2) ? $clog2(ALT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(ALT_CYCLES - 1);
    localparam logic [TW-1:0] T_HALF = TW'(ALT_CYCLES / 2);

    state_t        state;
    logic [7:0]    score;
    logic [7:0]    high;
    logic [TW-1:0] timer;

    logic [7:0]    score_inc;
    logic [7:0]    score_fin;

    bcd2_sat_inc u_inc (
        .val (score),
        .inc (score_inc)
    );

    // A point landing in the crash cycle still counts toward the final score.
    assign score_fin = point ? score_inc : score;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            score      <= 8'h00;
            high       <= 8'h00;
            timer      <= '0;
            new_record <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= PLAY;
                        score      <= 8'h00;
                        timer      <= '0;
                        new_record <= 1'b0;
                    end
                end
                PLAY: begin
                    if (crash) begin
                        state <= OVER_SCORE;
                        score <= score_fin;
                        timer <= '0;
                        if (score_fin > high) begin
                            high       <= score_fin;
                            new_record <= 1'b1;
                        end else begin
                            new_record <= 1'b0;
                        end
                    end else if (point) begin
                        score <= score_inc;
                    end
                end
                OVER_SCORE, OVER_HIGH: begin
                    // A new game takes priority over the phase toggle.
                    if (start) begin
                        state      <= PLAY;
                        score      <= 8'h00;
                        timer      <= '0;
                        new_record <= 1'b0;
                    end else if (timer == T_LAST) begin
                        state <= (state == OVER_SCORE) ? OVER_HIGH : OVER_SCORE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign disp_value = ((state == IDLE) || (state == OVER_HIGH)) ? high : score;
    // Record flash: blank during the first half of each final-score phase.
    assign disp_blank = new_record && (state == OVER_SCORE) && (timer < T_HALF);
    assign game_state = state;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with a short display phase.
module tb_score_display_ctrl;

    logic       clk;
    logic       clr;
    logic       start;
    logic       point;
    logic       crash;
    logic [7:0] disp_value;
    logic       disp_blank;
    logic       new_record;
    logic [1:0] game_state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    score_display_ctrl #(.ALT_CYCLES(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .point      (point),
        .crash      (crash),
        .disp_value (disp_value),
        .disp_blank (disp_blank),
        .new_record (new_record),
        .game_state (game_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs from a negedge; returns at the next negedge.
    task automatic step(input logic s, input logic p, input logic c);
        start = s;
        point = p;
        crash = c;
        @(negedge clk);
        start = 1'b0;
        point = 1'b0;
        crash = 1'b0;
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        point = 1'b0;
        crash = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("rst_value", disp_value, 8'h00);
        chk("rst_blank", {7'b0, disp_blank}, 8'h00);
        chk("rst_rec",   {7'b0, new_record}, 8'h00);
        chk("rst_state", {6'b0, game_state}, 8'h00);
        step(1'b0, 1'b1, 1'b1);
        chk("idle_ignores_pt", disp_value, 8'h00);
        chk("idle_ignores_crash", {6'b0, game_state}, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        chk("start_play", {6'b0, game_state}, 8'h01);
        chk("play_zero", disp_value, 8'h00);

        // Counting 1..12
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("count", disp_value, to_bcd(i));
            chk("count_nibbles",
                {7'b0, (disp_value[7:4] <= 4'd9) && (disp_value[3:0] <= 4'd9)}, 8'h01);
            step(1'b0, 1'b0, 1'b0);
            chk("count_hold", disp_value, to_bcd(i));
        end
        step(1'b1, 1'b0, 1'b0);
        chk("start_ignored_in_play", disp_value, 8'h12);

        // New record, then alternation
        step(1'b0, 1'b0, 1'b1);
        chk("rec_state", {6'b0, game_state}, 8'h02);
        chk("rec_flag",  {7'b0, new_record}, 8'h01);
        chk("rec_score", disp_value, 8'h12);
        chk("flash_c0",  {7'b0, disp_blank}, 8'h01);
        step(1'b0, 1'b1, 1'b0);
        chk("flash_c1",  {7'b0, disp_blank}, 8'h01);
        chk("over_ignores_pt", disp_value, 8'h12);
        step(1'b0, 1'b0, 1'b0);
        chk("flash_c2",  {7'b0, disp_blank}, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        chk("flash_c3",  {7'b0, disp_blank}, 8'h00);
        chk("still_score", {6'b0, game_state}, 8'h02);
        step(1'b0, 1'b0, 1'b0);
        chk("alt_high_state", {6'b0, game_state}, 8'h03);
        chk("alt_high_value", disp_value, 8'h12);
        chk("alt_high_blank", {7'b0, disp_blank}, 8'h00);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("alt_high_hold", {6'b0, game_state}, 8'h03);
        step(1'b0, 1'b0, 1'b0);
        chk("alt_back_score", {6'b0, game_state}, 8'h02);
        chk("alt_back_blank", {7'b0, disp_blank}, 8'h01);

        // No record, point and crash together
        step(1'b1, 1'b0, 1'b0);
        chk("restart_state", {6'b0, game_state}, 8'h01);
        chk("restart_value", disp_value, 8'h00);
        chk("restart_rec",   {7'b0, new_record}, 8'h00);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        chk("five", disp_value, 8'h05);
        step(1'b1, 1'b1, 1'b1);
        chk("pc_state", {6'b0, game_state}, 8'h02);
        chk("pc_score", disp_value, 8'h06);
        chk("pc_rec",   {7'b0, new_record}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("norec_blank", {7'b0, disp_blank}, 8'h00);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("norec_high_state", {6'b0, game_state}, 8'h03);
        chk("norec_high_kept",  disp_value, 8'h12);
        step(1'b1, 1'b0, 1'b0);
        chk("start_from_high", {6'b0, game_state}, 8'h01);
        chk("start_from_high_v", disp_value, 8'h00);

        // Saturation at 99
        for (int i = 1; i <= 101; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 98) chk("sat_98", disp_value, 8'h98);
            if (i >= 99) chk("sat_99", disp_value, 8'h99);
        end
        step(1'b0, 1'b0, 1'b1);
        chk("sat_record", {7'b0, new_record}, 8'h01);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("sat_high", disp_value, 8'h99);

        // Reset mid-game
        step(1'b1, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b1, 1'b0);
        chk("pre_clr", disp_value, 8'h07);
        #2 clr = 1'b1;
        #1;
        chk("clr_async_state", {6'b0, game_state}, 8'h00);
        chk("clr_async_value", disp_value, 8'h00);
        @(negedge clk);
        clr = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        chk("post_clr_pt", disp_value, 8'h00);
        chk("post_clr_idle", {6'b0, game_state}, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("post_clr_count", disp_value, 8'h01);
        step(1'b0, 1'b0, 1'b1);
        chk("post_clr_record", {7'b0, new_record}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
